// File: rtl/dcache_lsu.sv
// Load/store unit bridging CPU byte accesses to a data cache: alignment and
// legality checks, store lane replication, and load extraction/extension.
// Optional request watchdog under macro DCACHE_LSU_TIMEOUT_EN.
module dcache_lsu #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32,
    parameter int TOBITS   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] lsu_addr,
    input  logic [DATABITS-1:0] lsu_wdata,
    input  logic [2:0]          lsu_funct3,
    input  logic                lsu_rdreq,
    input  logic                lsu_wrreq,
    output logic [DATABITS-1:0] lsu_rdata,
    output logic                lsu_done,
    output logic                lsu_fault,
    output logic                lsu_busy,
    output logic [ADDRBITS-1:0] dcache_addr,
    output logic [DATABITS-1:0] dcache_in,
    output logic [1:0]          dcache_wordlen,
    output logic                dcache_rdreq,
    output logic                dcache_wrreq,
    input  logic [DATABITS-1:0] dcache_out,
    input  logic                dcache_valid,
    input  logic                dcache_busy
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDRBITS-1:0]   addr_q;
    logic [DATABITS-1:0]   din_q, din_d;
    logic [DATABITS-1:0]   rdata_q, load_ext;
    logic [2:0]            funct3_q;
    logic                  store_q, fault_q, fault_d;
    logic                  accept, acc_fault, load_capture, tmo_hit;
    logic [DATABITS-1:0]   shifted;

    assign accept = (state_q == IDLE) && (lsu_rdreq || lsu_wrreq);

    // Illegal combinations are caught at acceptance so the cache never sees them.
    always_comb begin
        acc_fault = 1'b0;
        if (lsu_rdreq && lsu_wrreq)
            acc_fault = 1'b1;
        if (lsu_funct3 == 3'd3 || lsu_funct3 == 3'd6 || lsu_funct3 == 3'd7)
            acc_fault = 1'b1;
        if (lsu_funct3[1:0] == 2'd1 && lsu_addr[0])
            acc_fault = 1'b1;
        if (lsu_funct3 == 3'd2 && lsu_addr[1:0] != 2'd0)
            acc_fault = 1'b1;
        if (lsu_wrreq && lsu_funct3[2])
            acc_fault = 1'b1;
    end

    always_comb begin
        case (lsu_funct3[1:0])
            2'd0:    din_d = {(DATABITS/8){lsu_wdata[7:0]}};
            2'd1:    din_d = {(DATABITS/16){lsu_wdata[15:0]}};
            default: din_d = lsu_wdata;
        endcase
    end

    assign shifted = dcache_out >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'd0:    load_ext = {{(DATABITS-8){shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{(DATABITS-16){shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {{(DATABITS-8){1'b0}}, shifted[7:0]};
            3'd5:    load_ext = {{(DATABITS-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef DCACHE_LSU_TIMEOUT_EN
    localparam logic [TOBITS-1:0] TMO_LAST = {{(TOBITS-1){1'b1}}, 1'b0};
    logic [TOBITS-1:0] tmo_q;

    // Fires in the REQ cycle whose increment would reach the all-ones count.
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tmo_q <= '0;
        else if (accept)
            tmo_q <= '0;
        else if (state_q == REQ)
            tmo_q <= tmo_q + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        load_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = acc_fault ? DONE : REQ;
                    fault_d = acc_fault;
                end
            end
            REQ: begin
                if (store_q && !dcache_busy) begin
                    state_d = DONE;
                end else if (!store_q && dcache_valid && !dcache_busy) begin
                    state_d      = DONE;
                    load_capture = 1'b1;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            din_q          <= '0;
            funct3_q       <= '0;
            store_q        <= 1'b0;
            fault_q        <= 1'b0;
            rdata_q        <= '0;
            dcache_wordlen <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (accept) begin
                addr_q         <= lsu_addr;
                din_q          <= din_d;
                funct3_q       <= lsu_funct3;
                store_q        <= lsu_wrreq;
                dcache_wordlen <= lsu_funct3[1:0];
            end
            if (load_capture)
                rdata_q <= load_ext;
        end
    end

    assign lsu_rdata    = rdata_q;
    assign lsu_busy     = (state_q != IDLE);
    assign lsu_done     = (state_q == DONE);
    assign lsu_fault    = (state_q == DONE) && fault_q;
    assign dcache_addr  = addr_q;
    assign dcache_in    = din_q;
    assign dcache_rdreq = (state_q == REQ) && !store_q;
    assign dcache_wrreq = (state_q == REQ) && store_q;
endmodule

// File: tb/tb_dcache_lsu.sv
// Scoreboard bench for dcache_lsu: stimulus pushes expected {fault, rdata},
// a monitor pops and compares on every lsu_done.
module tb_dcache_lsu;
`ifdef DCACHE_LSU_TIMEOUT_EN
    localparam int TB_TOBITS = 4;
`else
    localparam int TB_TOBITS = 8;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [2:0]  lsu_funct3 = '0;
    logic        lsu_rdreq = 1'b0, lsu_wrreq = 1'b0;
    logic [31:0] lsu_rdata;
    logic        lsu_done, lsu_fault, lsu_busy;
    logic [31:0] dcache_addr, dcache_in;
    logic [1:0]  dcache_wordlen;
    logic        dcache_rdreq, dcache_wrreq;
    logic [31:0] dcache_out = '0;
    logic        dcache_valid = 1'b0, dcache_busy = 1'b0;

    dcache_lsu #(.DATABITS(32), .ADDRBITS(32), .TOBITS(TB_TOBITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_funct3(lsu_funct3),
        .lsu_rdreq(lsu_rdreq), .lsu_wrreq(lsu_wrreq),
        .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_fault(lsu_fault),
        .lsu_busy(lsu_busy),
        .dcache_addr(dcache_addr), .dcache_in(dcache_in),
        .dcache_wordlen(dcache_wordlen),
        .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
        .dcache_out(dcache_out), .dcache_valid(dcache_valid),
        .dcache_busy(dcache_busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_rd = '0;
    bit req_seen = 1'b0, both_seen = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (dcache_rdreq || dcache_wrreq) req_seen = 1'b1;
        if (dcache_rdreq && dcache_wrreq) both_seen = 1'b1;
    end

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset_n && lsu_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(lsu_done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_fault", 64'(lsu_fault), 64'(e[32]));
                check("done_rdata", 64'(lsu_rdata), 64'(e[31:0]));
                $display("txn done: fault=%0d rdata=%08h", lsu_fault, lsu_rdata);
            end
        end
    end

    // Returns at the negedge inside the cycle after acceptance.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit efault, input logic [31:0] erd);
        @(negedge clk);
        lsu_rdreq = rd; lsu_wrreq = wr; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        exp_q.push_back({efault, erd});
        if (rd && !wr && !efault) last_rd = erd;
        @(negedge clk);
        lsu_rdreq = 1'b0; lsu_wrreq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && lsu_busy; i++) @(negedge clk);
        check(name, 64'(lsu_busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] erd);
        issue(1'b1, 1'b0, f3, a, '0, 1'b0, erd);
        wait_idle("load_idle");
    endtask

    task automatic fault_case(input string name, input bit rd, input bit wr,
                              input logic [2:0] f3, input logic [31:0] a);
        req_seen = 1'b0;
        issue(rd, wr, f3, a, 32'h55AA55AA, 1'b1, last_rd);
        check({name, "_done_early"}, 64'(lsu_done), 64'd1);
        wait_idle({name, "_idle"});
        check({name, "_no_cache_req"}, 64'(req_seen), 64'd0);
    endtask

    initial begin
        int hi;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outs_lsu", {lsu_rdata, lsu_done, lsu_fault, lsu_busy}, 64'd0);
        check("rst_outs_cache", {dcache_addr, dcache_wordlen, dcache_rdreq, dcache_wrreq}, 64'd0);
        check("rst_dcache_in", 64'(dcache_in), 64'd0);
        reset_n = 1'b1;

        // LW hit with latency
        dcache_valid = 1'b1; dcache_busy = 1'b0; dcache_out = 32'hDEADBEEF;
        issue(1'b1, 1'b0, 3'd2, 32'h100, '0, 1'b0, 32'hDEADBEEF);
        check("lw_req_n1", {dcache_rdreq, dcache_wrreq, lsu_done}, 64'b100);
        check("lw_addr", 64'(dcache_addr), 64'h100);
        check("lw_wordlen", 64'(dcache_wordlen), 64'd2);
        @(negedge clk);
        check("lw_done_n2", 64'(lsu_done), 64'd1);
        wait_idle("lw_idle");

        // Load extraction / extension
        dcache_out = 32'h80AABBCC;
        load(3'd0, 32'h103, 32'hFFFFFF80);
        load(3'd4, 32'h103, 32'h00000080);
        load(3'd5, 32'h102, 32'h000080AA);
        load(3'd1, 32'h102, 32'hFFFF80AA);
        load(3'd0, 32'h100, 32'hFFFFFFCC);
        load(3'd4, 32'h101, 32'h000000BB);

        // SH with cache busy for 20 cycles; a request while busy is ignored
        dcache_busy = 1'b1;
        issue(1'b0, 1'b1, 3'd1, 32'h102, 32'h1234ABCD, 1'b0, last_rd);
        check("sh_din", 64'(dcache_in), 64'hABCDABCD);
        check("sh_wordlen", 64'(dcache_wordlen), 64'd1);
        hi = dcache_wrreq ? 1 : 0;
        lsu_rdreq = 1'b1; lsu_funct3 = 3'd2; lsu_addr = 32'h200;
        @(negedge clk);
        lsu_rdreq = 1'b0;
        if (dcache_wrreq) hi++;
        repeat (18) begin
            @(negedge clk);
            if (dcache_wrreq) hi++;
        end
        check("sh_wrreq_held", 64'(hi), 64'd20);
        check("sh_addr_kept", 64'(dcache_addr), 64'h102);
        dcache_busy = 1'b0;
        @(negedge clk);
        check("sh_done_after_busy", 64'(lsu_done), 64'd1);
        wait_idle("sh_idle");

        issue(1'b0, 1'b1, 3'd0, 32'h001, 32'h000000EF, 1'b0, last_rd);
        check("sb_din", {dcache_in, 30'd0, dcache_wordlen}, {32'hEFEFEFEF, 32'd0});
        wait_idle("sb_idle");
        issue(1'b0, 1'b1, 3'd2, 32'h104, 32'h11223344, 1'b0, last_rd);
        check("sw_din", {dcache_in, 30'd0, dcache_wordlen}, {32'h11223344, 32'd2});
        wait_idle("sw_idle");

        // Faults at acceptance
        fault_case("lw_misaligned", 1'b1, 1'b0, 3'd2, 32'h101);
        fault_case("rd_wr_both", 1'b1, 1'b1, 3'd2, 32'h100);
        fault_case("lh_misaligned", 1'b1, 1'b0, 3'd1, 32'h101);
        fault_case("bad_funct3", 1'b1, 1'b0, 3'd3, 32'h100);
        fault_case("sbu_store", 1'b0, 1'b1, 3'd4, 32'h100);

        // Cache stuck busy
        dcache_busy = 1'b1;
`ifdef DCACHE_LSU_TIMEOUT_EN
        issue(1'b1, 1'b0, 3'd2, 32'h100, '0, 1'b1, last_rd);
        hi = 0;
        for (int i = 0; i < 100 && dcache_rdreq; i++) begin
            hi++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 64'(hi), 64'd15);
        check("tmo_done", {lsu_done, dcache_rdreq}, 64'b10);
        wait_idle("tmo_idle");
        issue(1'b1, 1'b0, 3'd2, 32'h100, '0, 1'b0, last_rd);
`else
        issue(1'b1, 1'b0, 3'd2, 32'h100, '0, 1'b0, last_rd);
        repeat (40) @(negedge clk);
        check("hang_in_req", {lsu_busy, dcache_rdreq, lsu_done}, 64'b110);
`endif

        // Asynchronous reset mid-REQ
        check("pre_rst_req", 64'(dcache_rdreq), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_req", {lsu_busy, lsu_done, dcache_rdreq, dcache_wrreq}, 64'd0);
        check("async_rst_data", {lsu_rdata, dcache_addr}, 64'd0);
        exp_q.delete();
        last_rd = '0;
        @(negedge clk);
        check("rst_idle", 64'(lsu_busy), 64'd0);
        reset_n = 1'b1;
        dcache_busy = 1'b0; dcache_out = 32'hCAFEF00D;
        load(3'd2, 32'h100, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("req_exclusive", 64'(both_seen), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
